// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg: shared types and constants for the boot loader.
// The FSM state encoding, the byte-lane index type and the number of bytes
// in a length header live here so the top and the byte packer agree on them.
package boot_loader_pkg;

  // FSM states; ST_ZERO is only reachable when zero fill is compiled in
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ZERO = 3'd1,
    ST_HDR  = 3'd2,
    ST_LOAD = 3'd3,
    ST_HOLD = 3'd4,
    ST_RUN  = 3'd5,
    ST_DONE = 3'd6,
    ST_ERR  = 3'd7
  } state_e;

  // Byte position inside a 32-bit little-endian word
  typedef logic [1:0] lane_t;

  // Bytes in the length header (and in every payload word)
  localparam int HDR_BYTES = 4;

  // Lane that completes a word
  localparam lane_t LAST_LANE = lane_t'(HDR_BYTES - 1);

  // busy covers every state that is actively loading or running the core
  function automatic logic is_busy_state(input logic [2:0] s);
    return !((s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR));
  endfunction

endpackage

// File: rtl/boot_loader_byte_packer.sv
// byte_packer: gathers four stream bytes little-endian (first byte lands in
// bits [7:0]) and presents the completed word together with a one-cycle
// word_valid strobe in the same cycle as the fourth byte handshake.
// Used for both the length header and the payload words.
module byte_packer
  import boot_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        fire,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_valid
);

  lane_t       lane;
  logic [23:0] low;

  // Lane counter and storage for the first three bytes of the word
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lane <= '0;
      low  <= '0;
    end else if (fire) begin
      // wraps from lane 3 back to lane 0, starting the next word
      lane <= lane + lane_t'(1);
      case (lane)
        2'd0:    low[7:0]   <= data;
        2'd1:    low[15:8]  <= data;
        2'd2:    low[23:16] <= data;
        default: ;
      endcase
    end
  end

  // The top byte comes straight from the stream so the word is ready on
  // the handshake of its last byte.
  assign word       = {data, low};
  assign word_valid = fire && (lane == LAST_LANE);

endmodule

// File: rtl/boot_loader.sv
// boot_loader: streams a length-prefixed little-endian image into the
// NPC unified memory, holds the core in reset while loading, releases it
// and flags the end of run when io_sync and io_simEnd coincide.
// Optional: define BOOT_LOADER_ZERO_FILL_EN to clear the whole memory
// (addresses 0..MEM_WORDS-1) before the header is accepted.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int          ADDR_W     = 22,
  parameter int unsigned MEM_WORDS  = 4194304,
  parameter int          RST_CYCLES = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset,
  input  logic              cpu_sync,
  input  logic              cpu_sim_end,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE = ST_IDLE;
  localparam logic [2:0] S_HDR  = ST_HDR;
  localparam logic [2:0] S_LOAD = ST_LOAD;
  localparam logic [2:0] S_HOLD = ST_HOLD;
  localparam logic [2:0] S_RUN  = ST_RUN;
  localparam logic [2:0] S_DONE = ST_DONE;
  localparam logic [2:0] S_ERR  = ST_ERR;

`ifdef BOOT_LOADER_ZERO_FILL_EN
  localparam logic [2:0]        S_ZERO    = ST_ZERO;
  localparam logic [2:0]        S_FIRST   = S_ZERO;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_WORDS - 1);
`else
  localparam logic [2:0]        S_FIRST   = S_HDR;
`endif

  // Hold counter counts RST_CYCLES-1 down to 0, one HOLD cycle per value
  localparam int               CNT_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [ADDR_W:0]  IDX_ONE   = (ADDR_W + 1)'(1);

  logic [2:0]       state;
  logic [2:0]       nxt;
  logic             fire;
  logic [31:0]      word;
  logic             word_valid;
  logic             len_over;
  logic             load_last;
  logic             last_wr;
  // One extra bit so a full-memory image reaches MEM_WORDS without wrapping
  logic [ADDR_W:0]  idx;
  logic [ADDR_W:0]  idx_inc;
  logic [ADDR_W:0]  len_q;
  logic [CNT_W-1:0] hold_cnt;

  assign fire      = in_valid && in_ready;
  assign idx_inc   = idx + IDX_ONE;
  assign len_over  = word > MEM_WORDS;
  // Last payload word is being handed to the write port this cycle
  assign load_last = (state == S_LOAD) && word_valid && (idx_inc == len_q);

  byte_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .fire       (fire),
    .data       (in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  // Next-state decode
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (start) nxt = S_FIRST;
`ifdef BOOT_LOADER_ZERO_FILL_EN
      S_ZERO: if (mem_waddr == LAST_ADDR) nxt = S_HDR;
`endif
      S_HDR: begin
        if (word_valid) begin
          if (word == '0)    nxt = S_HOLD;
          else if (len_over) nxt = S_ERR;
          else               nxt = S_LOAD;
        end
      end
      // Stay in LOAD for the cycle the final write is on the port
      S_LOAD: if (last_wr) nxt = S_HOLD;
      S_HOLD: if (hold_cnt == '0) nxt = S_RUN;
      S_RUN:  if (cpu_sync && cpu_sim_end) nxt = S_DONE;
      default: nxt = state;
    endcase
  end

  // State register; DONE and ERR are only left through reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= nxt;
  end

  // Length capture, word index and the last-write marker
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_q   <= '0;
      idx     <= '0;
      last_wr <= 1'b0;
    end else begin
      last_wr <= load_last;
      if ((state == S_HDR) && word_valid) begin
        len_q <= word[ADDR_W:0];
        idx   <= '0;
      end else if ((state == S_LOAD) && word_valid) begin
        idx <= idx_inc;
      end
    end
  end

  // Memory write port: payload words, plus the clearing sweep when enabled
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_wen   <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
    end else begin
      mem_wen <= 1'b0;
      if ((state == S_LOAD) && word_valid) begin
        mem_wen   <= 1'b1;
        mem_waddr <= idx[ADDR_W-1:0];
        mem_wdata <= word;
      end
`ifdef BOOT_LOADER_ZERO_FILL_EN
      else if (nxt == S_ZERO) begin
        mem_wen   <= 1'b1;
        mem_waddr <= (state == S_IDLE) ? '0 : mem_waddr + ADDR_W'(1);
        mem_wdata <= '0;
      end
`endif
    end
  end

  // Core reset hold counter, loaded on entry to HOLD
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_cnt <= '0;
    end else if ((nxt == S_HOLD) && (state != S_HOLD)) begin
      hold_cnt <= HOLD_LAST;
    end else if ((state == S_HOLD) && (hold_cnt != '0)) begin
      hold_cnt <= hold_cnt - CNT_W'(1);
    end
  end

  // Registered status outputs, decoded from the state being entered
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_ready  <= 1'b0;
      cpu_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // Ready drops as the last word issues so no byte past len*4 is taken
      in_ready  <= ((nxt == S_HDR) || (nxt == S_LOAD)) && !load_last;
      cpu_reset <= (nxt != S_RUN);
      busy      <= is_busy_state(nxt);
      done      <= (nxt == S_DONE);
      err       <= (nxt == S_ERR);
    end
  end

endmodule
